// File: rtl/doff_pkg.sv
// Shared types and constants for the dump-off arbiter slice.
package doff_pkg;

    localparam int unsigned NUM_SRC = 3;

    typedef logic [1:0] src_idx_t;

    // Mux select encoding driven on `change`
    localparam src_idx_t SEL_SRC0 = 2'd0;
    localparam src_idx_t SEL_SRC1 = 2'd1;
    localparam src_idx_t SEL_SRC2 = 2'd2;

    // Legacy state codes, kept so existing decode logic still matches
    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_PRE_GAP  = 2'd1;
    localparam logic [1:0] ST_OWN      = 2'd2;
    localparam logic [1:0] ST_POST_GAP = 2'd3;

    typedef enum logic [1:0] {
        IDLE     = ST_IDLE,
        PRE_GAP  = ST_PRE_GAP,
        OWN      = ST_OWN,
        POST_GAP = ST_POST_GAP
    } state_t;

endpackage

// File: rtl/doff_arb_ctrl_if.sv
// Source-side request/level bundle and controller status outputs.
interface doff_arb_ctrl_if;
    import doff_pkg::*;

    logic [NUM_SRC-1:0] req;
    logic [NUM_SRC-1:0] dumpoffin;
    logic [NUM_SRC-1:0] grant;
    src_idx_t           change;
    logic               dumpoff;
    logic               busy;
    logic [NUM_SRC-1:0] tmo_err;

    // Sources / sequencers side
    modport master (
        output req, dumpoffin,
        input  grant, change, dumpoff, busy, tmo_err
    );

    // Arbiter side
    modport slave (
        input  req, dumpoffin,
        output grant, change, dumpoff, busy, tmo_err
    );

endinterface

// File: rtl/doff_rr_pick.sv
// Combinational round-robin picker: searches ptr+1, ptr+2, ptr (mod 3).
module doff_rr_pick
    import doff_pkg::*;
(
    input  logic [NUM_SRC-1:0] req,
    input  src_idx_t           ptr,
    output logic               valid,
    output src_idx_t           winner
);

    src_idx_t cand;

    // First requesting source after the pointer wins
    always_comb begin
        valid  = 1'b0;
        winner = ptr;
        cand   = ptr;
        for (int unsigned k = 1; k <= NUM_SRC; k++) begin
            cand = src_idx_t'((32'(ptr) + k) % NUM_SRC);
            if (!valid && req[cand]) begin
                valid  = 1'b1;
                winner = cand;
            end
        end
    end

endmodule

// File: rtl/doff_arb_ctrl.sv
// Dump-off mux arbiter/sequencer with dead-time gaps around ownership.
// Optional ownership watchdog enabled by defining DOFF_TMO_EN.
module doff_arb_ctrl
    import doff_pkg::*;
#(
    parameter int unsigned GAP_CYC  = 4,
    parameter logic        SAFE_LVL = 1'b0,
    parameter int unsigned TMO_CYC  = 1000
) (
    input  logic           clk,
    input  logic           rst_n,
    doff_arb_ctrl_if.slave bus
);

    localparam logic [7:0] GAP_LOAD = 8'(GAP_CYC - 1);

    state_t             state;
    src_idx_t           tgt;
    src_idx_t           ptr;
    src_idx_t           change_r;
    logic [7:0]         gap_cnt;
    logic [NUM_SRC-1:0] grant_r;
    logic               dumpoff_r;
    logic [NUM_SRC-1:0] mask;
    logic [NUM_SRC-1:0] tmo_err_r;
    logic               tmo_hit;
    logic               pick_valid;
    src_idx_t           pick;

    doff_rr_pick u_pick (
        .req    (bus.req & ~mask),
        .ptr    (ptr),
        .valid  (pick_valid),
        .winner (pick)
    );

`ifdef DOFF_TMO_EN
    logic [15:0] tmo_cnt;

    // Timeout only counts when the owner is still requesting; a same-cycle drop is a normal release
    assign tmo_hit = (state == OWN) && bus.req[tgt] && (tmo_cnt == 16'(TMO_CYC - 1));

    // Ownership watchdog, sticky error flags and re-arbitration mask
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tmo_cnt   <= '0;
            mask      <= '0;
            tmo_err_r <= '0;
        end else begin
            tmo_cnt <= (state == OWN) ? tmo_cnt + 16'd1 : '0;
            mask    <= mask & bus.req;
            if (tmo_hit) begin
                mask[tgt]      <= 1'b1;
                tmo_err_r[tgt] <= 1'b1;
            end
        end
    end
`else
    assign tmo_hit   = 1'b0;
    assign mask      = '0;
    assign tmo_err_r = '0;
`endif

    // Main sequencer: arbitration, dead-time gaps and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            tgt       <= SEL_SRC0;
            ptr       <= SEL_SRC2;
            change_r  <= SEL_SRC0;
            gap_cnt   <= '0;
            grant_r   <= '0;
            dumpoff_r <= SAFE_LVL;
        end else begin
            case (state)
                IDLE: begin
                    grant_r   <= '0;
                    dumpoff_r <= SAFE_LVL;
                    if (pick_valid) begin
                        tgt      <= pick;
                        change_r <= pick;
                        gap_cnt  <= GAP_LOAD;
                        state    <= PRE_GAP;
                    end
                end
                PRE_GAP: begin
                    dumpoff_r <= SAFE_LVL;
                    if (gap_cnt == '0) begin
                        if (bus.req[tgt]) begin
                            grant_r <= NUM_SRC'(1) << tgt;
                            state   <= OWN;
                        end else begin
                            grant_r <= '0;
                            state   <= IDLE;
                        end
                    end else begin
                        grant_r <= '0;
                        gap_cnt <= gap_cnt - 8'd1;
                    end
                end
                OWN: begin
                    if (!bus.req[tgt] || tmo_hit) begin
                        ptr       <= tgt;
                        gap_cnt   <= GAP_LOAD;
                        grant_r   <= '0;
                        dumpoff_r <= SAFE_LVL;
                        state     <= POST_GAP;
                    end else begin
                        dumpoff_r <= bus.dumpoffin[tgt];
                    end
                end
                POST_GAP: begin
                    grant_r   <= '0;
                    dumpoff_r <= SAFE_LVL;
                    if (gap_cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 8'd1;
                    end
                end
                default: begin
                    grant_r   <= '0;
                    dumpoff_r <= SAFE_LVL;
                    state     <= IDLE;
                end
            endcase
        end
    end

    assign bus.grant   = grant_r;
    assign bus.change  = change_r;
    assign bus.dumpoff = dumpoff_r;
    assign bus.busy    = (state != IDLE);
    assign bus.tmo_err = tmo_err_r;

endmodule

// File: doc/doff_arb_ctrl.md
# doff_arb_ctrl

Arbiter and sequencer for the dump-off (Q-damping) selection mux. It accepts ownership requests from three dump-off sources (dumpoffin0..2) and drives the 2-bit source select `change`. It also produces a registered, glitch-free `dumpoff` that is forced to a safe level for a programmable dead time around every ownership change. It sits between the pulse-sequence generators and the damping switch driver, so no two sources can ever be mux-selected back-to-back without a dead gap.

## Interface
- `GAP_CYC`, 4 — dead-time cycles at safe level, before each grant and after each release; legal range 1..255.
- `SAFE_LVL`, 1'b0 — dumpoff level driven whenever no source owns the line.
- `TMO_CYC`, 1000 — ownership watchdog limit in cycles; used only with `DOFF_TMO_EN`; 16-bit counter.
- `clk`  in  1  system clock.
- `rst_n`  in  1  synchronous active-low reset.
- `req`  in  3  level request per source; held high for the whole ownership period.
- `dumpoffin`  in  3  dump-off level from sources 0..2.
- `grant`  out  3  one-hot ownership indication; all zero when unowned.
- `change`  out  2  mux select; only values 0..2 are ever driven.
- `dumpoff`  out  1  registered dump-off output.
- `busy`  out  1  high whenever the state is not IDLE.
- `tmo_err`  out  3  sticky per-source watchdog flag; cleared only by reset.

## Operation
- Reset values: state IDLE, `grant`=0, `change`=0, `dumpoff`=SAFE_LVL, `busy`=0, `tmo_err`=0, RR pointer=2, so source 0 wins first.
- States: IDLE, PRE_GAP, OWN, POST_GAP.
- IDLE:
  - If any `req` bit is high, pick a winner round-robin in the order ptr+1, ptr+2, ptr (mod 3).
  - Latch the winner as `tgt`, set `change`<=tgt, load gap counter with GAP_CYC-1, go to PRE_GAP.
- PRE_GAP:
  - `grant`=0, `dumpoff`=SAFE_LVL; `change` holds tgt.
  - Counter decrements each cycle.
  - At counter 0: if req[tgt] is high, go to OWN; else go to IDLE. An abandoned request costs no ownership and leaves the pointer unchanged.
- OWN:
  - grant[tgt]=1.
  - `dumpoff` <= dumpoffin[tgt] each cycle.
  - When req[tgt] falls: ptr<=tgt, load counter with GAP_CYC-1, go to POST_GAP.
  - Requests from other sources are ignored while in OWN; no preemption.
- POST_GAP:
  - `grant`=0, `dumpoff`=SAFE_LVL; `change` holds the old tgt.
  - At counter 0, go to IDLE.
- Non-target `dumpoffin` bits never reach `dumpoff`.
- `change` only updates in the IDLE→PRE_GAP transition, i.e. while `dumpoff` is already at safe level.

## Timing
- Request of an idle line:
  - `req` sampled high at edge N → PRE_GAP from N+1.
  - `grant` asserts at edge N+1+GAP_CYC.
  - First sourced `dumpoff` appears at edge N+2+GAP_CYC.
- Input-to-output latency: `dumpoff` lags `dumpoffin`[tgt] by exactly 1 cycle during OWN.
- Release:
  - req[tgt] sampled low at edge M → `grant`=0 and `dumpoff`=SAFE_LVL from M+1.
  - IDLE is reached at M+1+GAP_CYC.
- Owner-to-owner handover: minimum 2·GAP_CYC+1 cycles with `dumpoff` at safe level.
- Simultaneous requests are resolved by round-robin only; with all three held, the grant sequence is 0,1,2,0.
- Reset asserted mid-OWN takes effect at the next edge: `grant`=0 and `dumpoff`=SAFE_LVL immediately, with no post gap.

## Configuration
- `DOFF_TMO_EN` defined:
  - A 16-bit counter runs in OWN.
  - On reaching TMO_CYC, the controller behaves as a release: it sets tmo_err[tgt] and goes to POST_GAP.
  - That source is masked from arbitration until its `req` is seen low for at least one cycle.
- `DOFF_TMO_EN` undefined:
  - No counter and no mask.
  - `tmo_err` is tied to 0.
  - Ownership is unbounded.

## Structure
- Package `doff_pkg` holds:
  - state enum (IDLE, PRE_GAP, OWN, POST_GAP);
  - `NUM_SRC`=3;
  - the 2-bit source index type;
  - the select encoding constants.
- Sub-module `doff_rr_pick` is the combinational round-robin picker. Inputs: 3-bit request vector after mask, and 2-bit pointer. Outputs: `valid` and the 2-bit winner.
- The FSM, gap counter, watchdog counter and output registers live in `doff_arb_ctrl`.

## Test plan
- Reset, then req=3'b001 held, GAP_CYC=4:
  - grant=3'b001 exactly 5 cycles after the request edge;
  - change=0 throughout;
  - dumpoff follows dumpoffin0 with 1-cycle lag;
  - after req drops, dumpoff=0 for 4 cycles and busy falls.
- req=3'b111 held after each release: grant order 001, 010, 100, 001; every handover shows ≥9 safe cycles; change steps 0,1,2,0.
- req1 pulsed high for 2 cycles only: PRE_GAP ends with req1 low → returns to IDLE; grant never asserts; the next req1 still wins first, i.e. the pointer is unchanged.
- Toggle dumpoffin1 and dumpoffin2 every cycle while source 0 owns: dumpoff reflects only dumpoffin0.
- rst_n low for 1 cycle mid-OWN: the next edge shows grant=0, dumpoff=SAFE_LVL, change=0, busy=0.
- With `DOFF_TMO_EN` defined and TMO_CYC=20, req2 held:
  - grant2 drops after 20 cycles and tmo_err=3'b100;
  - source 2 is not regranted until req2 goes low then high again.
